// File: rtl/tt_mux_pkg.sv
// rtl/tt_mux_pkg.sv - shared state encoding and bus field offsets for the project mux
package tt_mux_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QUIESCE,
        ST_SWITCH,
        ST_RESET,
        ST_RUN
    } mux_state_t;

    localparam int ADDR_W = 5;

    // Shared input bus fanned out to every project: {uio_in, ui_in, proj_rst_n, proj_clk}
    localparam int IW_CLK = 0;
    localparam int IW_RST = 1;
    localparam int IW_UI  = 2;
    localparam int IW_UIO = 10;
    localparam int IW_W   = 18;

    // Per-project output slice: {uio_oe, uio_out, uo_out}
    localparam int OW_UO      = 0;
    localparam int OW_UIO_OUT = 8;
    localparam int OW_UIO_OE  = 16;
    localparam int OW_W       = 24;

    localparam int QUIESCE_CYCLES = 2;

endpackage

// File: rtl/tt_mux_out_sel.sv
// rtl/tt_mux_out_sel.sv - selects one project's output slice and registers it onto the pads
module tt_mux_out_sel
    import tt_mux_pkg::*;
#(
    parameter int NUM_PROJ = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [OW_W*NUM_PROJ-1:0]   ow_bus,
    input  logic [ADDR_W-1:0]          sel,
    input  logic                       run,
    output logic [7:0]                 uo_out,
    output logic [7:0]                 uio_out,
    output logic [7:0]                 uio_oe
);

    logic [OW_W-1:0] slice;

    // Explicit compare-and-pick so unselected slices can never leak X onto the pads
    always_comb begin
        slice = '0;
        for (int p = 0; p < NUM_PROJ; p++) begin
            if (sel == ADDR_W'(p)) begin
                slice = ow_bus[p*OW_W +: OW_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uo_out  <= '0;
            uio_out <= '0;
            uio_oe  <= '0;
        end else if (run) begin
            uo_out  <= slice[OW_UO      +: 8];
            uio_out <= slice[OW_UIO_OUT +: 8];
            uio_oe  <= slice[OW_UIO_OE  +: 8];
        end else begin
            uo_out  <= '0;
            uio_out <= '0;
            uio_oe  <= '0;
        end
    end

endmodule

// File: rtl/tt_mux_ctrl.sv
// rtl/tt_mux_ctrl.sv - project select FSM: quiesce, switch, reset and run one of NUM_PROJ projects
module tt_mux_ctrl
    import tt_mux_pkg::*;
#(
    parameter int NUM_PROJ   = 4,
    parameter int RST_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sel_req,
    input  logic                       sel_off,
    input  logic [ADDR_W-1:0]          sel_addr,
    input  logic                       proj_clk,
    input  logic [7:0]                 ui_in,
    input  logic [7:0]                 uio_in,
    input  logic [OW_W*NUM_PROJ-1:0]   ow_bus,
    output logic [IW_W-1:0]            iw,
    output logic [NUM_PROJ-1:0]        ena,
    output logic [7:0]                 uo_out,
    output logic [7:0]                 uio_out,
    output logic [7:0]                 uio_oe,
    output logic [ADDR_W-1:0]          cur_addr,
    output logic                       active,
    output logic                       sel_busy,
    output logic                       sel_err
);

    localparam logic [NUM_PROJ-1:0] ENA_ONE = NUM_PROJ'(1);

    mux_state_t        state;
    logic [7:0]        cnt;
    logic [ADDR_W-1:0] req_addr;
    logic              req_off;
    logic              proj_rst_n;
    logic              addr_ok;

    assign addr_ok = int'(sel_addr) < NUM_PROJ;

    assign iw[IW_CLK]      = proj_clk;
    assign iw[IW_RST]      = proj_rst_n;
    assign iw[IW_UI  +: 8] = ui_in;
    assign iw[IW_UIO +: 8] = uio_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ena        <= '0;
            proj_rst_n <= 1'b0;
            cur_addr   <= '0;
            active     <= 1'b0;
            sel_busy   <= 1'b0;
            sel_err    <= 1'b0;
            cnt        <= '0;
            req_addr   <= '0;
            req_off    <= 1'b0;
        end else begin
            sel_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Nothing is running, so there is nothing to quiesce and sel_off has no meaning
                    if (sel_req && !sel_off) begin
                        if (addr_ok) begin
                            state    <= ST_SWITCH;
                            req_addr <= sel_addr;
                            req_off  <= 1'b0;
                            sel_busy <= 1'b1;
                        end else begin
                            sel_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (sel_off || sel_req) begin
                        if (sel_off || addr_ok) begin
                            state      <= ST_QUIESCE;
                            req_off    <= sel_off;
                            req_addr   <= sel_off ? cur_addr : sel_addr;
                            cnt        <= '0;
                            proj_rst_n <= 1'b0;
                            active     <= 1'b0;
                            sel_busy   <= 1'b1;
                        end else begin
                            sel_err <= 1'b1;
                        end
                    end
                end
                ST_QUIESCE: begin
                    if (cnt == 8'(QUIESCE_CYCLES - 1)) begin
                        state <= ST_SWITCH;
                        ena   <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_SWITCH: begin
                    cur_addr <= req_addr;
                    if (req_off) begin
                        state    <= ST_IDLE;
                        sel_busy <= 1'b0;
                    end else begin
                        state <= ST_RESET;
                        ena   <= ENA_ONE << req_addr;
                        cnt   <= '0;
                    end
                end
                ST_RESET: begin
                    if (cnt == 8'(RST_CYCLES - 1)) begin
                        state      <= ST_RUN;
                        proj_rst_n <= 1'b1;
                        active     <= 1'b1;
                        sel_busy   <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ena   <= '0;
                end
            endcase
        end
    end

    // active is high exactly while in RUN, which is the pad gating condition
    tt_mux_out_sel #(
        .NUM_PROJ (NUM_PROJ)
    ) u_out_sel (
        .clk     (clk),
        .rst_n   (rst_n),
        .ow_bus  (ow_bus),
        .sel     (cur_addr),
        .run     (active),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

endmodule

// File: tb/tb_tt_mux_ctrl.sv
// tb/tb_tt_mux_ctrl.sv - scoreboard bench for the project select FSM and pad output path
module tb_tt_mux_ctrl;

    localparam int NP = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sel_req;
    logic          sel_off;
    logic [4:0]    sel_addr;
    logic          proj_clk;
    logic [7:0]    ui_in;
    logic [7:0]    uio_in;
    logic [24*NP-1:0] ow_bus;
    logic [17:0]   iw;
    logic [NP-1:0] ena;
    logic [7:0]    uo_out;
    logic [7:0]    uio_out;
    logic [7:0]    uio_oe;
    logic [4:0]    cur_addr;
    logic          active;
    logic          sel_busy;
    logic          sel_err;

    tt_mux_ctrl #(
        .NUM_PROJ   (NP),
        .RST_CYCLES (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel_req  (sel_req),
        .sel_off  (sel_off),
        .sel_addr (sel_addr),
        .proj_clk (proj_clk),
        .ui_in    (ui_in),
        .uio_in   (uio_in),
        .ow_bus   (ow_bus),
        .iw       (iw),
        .ena      (ena),
        .uo_out   (uo_out),
        .uio_out  (uio_out),
        .uio_oe   (uio_oe),
        .cur_addr (cur_addr),
        .active   (active),
        .sel_busy (sel_busy),
        .sel_err  (sel_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       nm;
        logic [53:0] v;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [53:0] act_v;
    assign act_v = {ena, iw, active, sel_busy, sel_err, cur_addr, uio_oe, uio_out, uo_out};

    // Monitor: every expectation is stamped with the cycle in which it must be observed
    always @(negedge clk) begin
        exp_t x;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            x = q.pop_front();
            checks++;
            if (x.cyc != cyc) begin
                errors++;
                $display("FAIL %s: observed in cycle %0d, required cycle %0d", x.nm, cyc, x.cyc);
            end else if (act_v !== x.v) begin
                errors++;
                $display("FAIL %s: got ena=%b iw=%h act=%b busy=%b err=%b addr=%0d pads=%h, want ena=%b iw=%h act=%b busy=%b err=%b addr=%0d pads=%h",
                         x.nm, act_v[53:50], act_v[49:32], act_v[31], act_v[30], act_v[29], act_v[28:24], act_v[23:0],
                         x.v[53:50], x.v[49:32], x.v[31], x.v[30], x.v[29], x.v[28:24], x.v[23:0]);
            end
        end
    end

    task automatic expect_st(input string nm, input logic [3:0] e, input logic r, input logic a,
                             input logic b, input logic er, input logic [4:0] ad, input logic [23:0] pd);
        exp_t x;
        x.cyc = cyc;
        x.nm  = nm;
        x.v   = {e, 8'hC3, 8'h5A, r, proj_clk, a, b, er, ad, pd};
        q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sel_req  = 1'b0;
        sel_off  = 1'b0;
        proj_clk = ~proj_clk;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        sel_req  = 1'b0;
        sel_off  = 1'b0;
        sel_addr = 5'd0;
        proj_clk = 1'b0;
        ui_in    = 8'h5A;
        uio_in   = 8'hC3;
        ow_bus   = {24'h333333, 24'h123456, 24'h222222, 24'h111111};

        tick(); expect_st("reset",      4'b0000, 0, 0, 0, 0, 5'd0, 24'h0);
        tick(); expect_st("reset_hold", 4'b0000, 0, 0, 0, 0, 5'd0, 24'h0);
        rst_n = 1'b1;
        tick(); expect_st("idle",       4'b0000, 0, 0, 0, 0, 5'd0, 24'h0);
        sel_req = 1'b1; sel_addr = 5'd2;
        tick(); expect_st("switch",     4'b0000, 0, 0, 1, 0, 5'd0, 24'h0);
        for (int i = 0; i < 8; i++) begin
            tick(); expect_st("reset_p2", 4'b0100, 0, 0, 1, 0, 5'd2, 24'h0);
            if (i == 2) begin
                sel_req = 1'b1; sel_addr = 5'd1;
            end
        end
        tick(); expect_st("run_p2",     4'b0100, 1, 1, 0, 0, 5'd2, 24'h0);
        tick(); expect_st("run_pads",   4'b0100, 1, 1, 0, 0, 5'd2, 24'h123456);
        ow_bus[2*24 +: 24] = 24'hFFA53C;
        ow_bus[0*24 +: 24] = 24'hDEAD00;
        tick(); expect_st("run_new",    4'b0100, 1, 1, 0, 0, 5'd2, 24'hFFA53C);
        ow_bus[3*24 +: 24] = 24'hABCDEF;
        tick(); expect_st("run_ignore", 4'b0100, 1, 1, 0, 0, 5'd2, 24'hFFA53C);
        sel_req = 1'b1; sel_addr = 5'd7;
        tick(); expect_st("err_pulse",  4'b0100, 1, 1, 0, 1, 5'd2, 24'hFFA53C);
        tick(); expect_st("err_clear",  4'b0100, 1, 1, 0, 0, 5'd2, 24'hFFA53C);
        sel_req = 1'b1; sel_addr = 5'd1;
        tick(); expect_st("quiesce1",   4'b0100, 0, 0, 1, 0, 5'd2, 24'hFFA53C);
        tick(); expect_st("quiesce2",   4'b0100, 0, 0, 1, 0, 5'd2, 24'h0);
        tick(); expect_st("switch2",    4'b0000, 0, 0, 1, 0, 5'd2, 24'h0);
        for (int i = 0; i < 8; i++) begin
            tick(); expect_st("reset_p1", 4'b0010, 0, 0, 1, 0, 5'd1, 24'h0);
        end
        tick(); expect_st("run_p1",      4'b0010, 1, 1, 0, 0, 5'd1, 24'h0);
        tick(); expect_st("run_p1_pads", 4'b0010, 1, 1, 0, 0, 5'd1, 24'h222222);
        sel_off = 1'b1; sel_req = 1'b1; sel_addr = 5'd3;
        tick(); expect_st("off_q1",     4'b0010, 0, 0, 1, 0, 5'd1, 24'h222222);
        tick(); expect_st("off_q2",     4'b0010, 0, 0, 1, 0, 5'd1, 24'h0);
        tick(); expect_st("off_switch", 4'b0000, 0, 0, 1, 0, 5'd1, 24'h0);
        tick(); expect_st("off_idle",   4'b0000, 0, 0, 0, 0, 5'd1, 24'h0);
        sel_off = 1'b1;
        tick(); expect_st("idle_off_ignored", 4'b0000, 0, 0, 0, 0, 5'd1, 24'h0);
        sel_req = 1'b1; sel_addr = 5'd3;
        tick(); expect_st("switch3",    4'b0000, 0, 0, 1, 0, 5'd1, 24'h0);
        for (int i = 0; i < 3; i++) begin
            tick(); expect_st("reset_p3", 4'b1000, 0, 0, 1, 0, 5'd3, 24'h0);
        end
        tick();
        #2;
        rst_n = 1'b0;
        expect_st("async_rst",      4'b0000, 0, 0, 0, 0, 5'd0, 24'h0);
        tick(); expect_st("async_rst_hold", 4'b0000, 0, 0, 0, 0, 5'd0, 24'h0);
        rst_n = 1'b1;
        tick(); expect_st("post_rst_idle",  4'b0000, 0, 0, 0, 0, 5'd0, 24'h0);
        tick(); expect_st("post_rst_idle2", 4'b0000, 0, 0, 0, 0, 5'd0, 24'h0);
        tick();
        tick();
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_mux_ctrl.md
TT_MUX_CTRL -- requirements
Module: tt_mux_ctrl

Interface
REQ-001 NUM_PROJ, 4, number of attached project wrappers (2..32).
REQ-002 RST_CYCLES, 8, cycles project reset is held low after selection (2..255).
REQ-003 clk  in  1  system clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 sel_req  in  1  single-cycle pulse: select project sel_addr.
REQ-006 sel_off  in  1  single-cycle pulse: deselect current project.
REQ-007 sel_addr  in  5  requested project index.
REQ-008 proj_clk  in  1  project clock, passed to the project bus.
REQ-009 ui_in  in  8  dedicated pad inputs.
REQ-010 uio_in  in  8  bidirectional pad inputs.
REQ-011 ow_bus  in  24*NUM_PROJ  packed project outputs; slice p = {uio_oe, uio_out, uo_out}.
REQ-012 iw  out  18  shared project bus {uio_in, ui_in, proj_rst_n, proj_clk}.
REQ-013 ena  out  NUM_PROJ  one-hot project enable.
REQ-014 uo_out, uio_out, uio_oe  out  8 each  registered pad outputs.
REQ-015 cur_addr  out  5  selected index; active  out  1  high in RUN; sel_busy  out  1  high in QUIESCE/SWITCH/RESET; sel_err  out  1  one-cycle error pulse.

Function
REQ-016 iw[0] SHALL be proj_clk combinationally, iw[9:2]=ui_in, iw[17:10]=uio_in, iw[1]=registered proj_rst_n.
REQ-017 FSM states: IDLE, QUIESCE, SWITCH, RESET, RUN.
REQ-018 IDLE: ena=0, proj_rst_n=0; sel_req valid -> SWITCH (QUIESCE skipped).
REQ-019 RUN: ena[cur_addr]=1, proj_rst_n=1; sel_req valid or sel_off -> QUIESCE.
REQ-020 QUIESCE: exactly 2 cycles, old ena held, proj_rst_n=0; then SWITCH.
REQ-021 SWITCH: 1 cycle, ena=0; cur_addr <= latched request; next RESET, or IDLE if sel_off was the cause.
REQ-022 RESET: ena[cur_addr]=1, proj_rst_n=0 for exactly RST_CYCLES cycles; then RUN.
REQ-023 sel_addr and request type latched in the cycle sel_req/sel_off is accepted.
REQ-024 sel_addr >= NUM_PROJ: request ignored, sel_err high the next cycle, state unchanged.
REQ-025 sel_req/sel_off while sel_busy: ignored, no sel_err.
REQ-026 sel_req and sel_off same cycle: sel_off wins; sel_off in IDLE: ignored.
REQ-027 Reselecting the current address SHALL run the full QUIESCE/SWITCH/RESET sequence.
REQ-028 Pad outputs SHALL be registered, 1-cycle latency from ow_bus slice cur_addr when active (state RUN in the sampling cycle); 0 otherwise.
REQ-029 uio_oe forced 0 outside RUN; no X propagation from unselected slices.

Reset
REQ-030 rst_n low asynchronously forces IDLE, ena=0, iw[1]=0, cur_addr=0, active=0, sel_busy=0, sel_err=0, pad outputs 0.
REQ-031 Reset mid-sequence SHALL abandon the sequence; no request remembered after release.

Structure
REQ-032 Package tt_mux_pkg SHALL hold the state enum and iw/ow field offsets (IW_CLK=0, IW_RST=1, IW_UI=2, IW_UIO=10; OW_UO=0, OW_UIO_OUT=8, OW_UIO_OE=16).
REQ-033 One sub-module tt_mux_out_sel: slice mux plus output register with RUN gating.

Verification
REQ-034 Reset, sel_req addr=2 -> SWITCH 1 cycle, ena=0100 for 8 cycles with iw[1]=0, then active=1, iw[1]=1.
REQ-035 In RUN addr=2, ow_bus slice 2 = 0xFF_A5_3C -> next cycle uio_oe=0xFF, uio_out=0xA5, uo_out=0x3C; other slices changes ignored.
REQ-036 RUN addr=2, sel_req addr=1 -> 2 cycles ena=0100 with iw[1]=0, 1 cycle ena=0, 8 cycles ena=0010, then RUN, cur_addr=1.
REQ-037 sel_req addr=7 with NUM_PROJ=4 -> sel_err pulse 1 cycle, state/ena unchanged.
REQ-038 sel_req during RESET -> ignored; sel_off from RUN -> IDLE after 3 cycles, all pad outputs 0.
REQ-039 rst_n low during RESET -> ena=0, iw[1]=0 immediately, IDLE after release.
